// File: rtl/axi_pmu_streamer.sv
// axi_pmu_streamer: snapshots the PMU counter bank on a software or periodic
// trigger and ships it as one fixed-length framed 32-bit AXI-Stream packet.
// Frame = header {SYNC_TAG, NUM_COUNTERS, seq} + low/high halves of each counter.
module axi_pmu_streamer #(
  parameter int          NUM_COUNTERS = 19,
  parameter int          ADDR_WIDTH   = 5,
  parameter int          PERIOD_WIDTH = 32,
  parameter logic [15:0] SYNC_TAG     = 16'hA55A
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    trigger_i,
  input  logic [PERIOD_WIDTH-1:0] period_i,
  output logic [ADDR_WIDTH-1:0]   pmu_addr_o,
  input  logic [63:0]             pmu_data_i,
  output logic [31:0]             m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic                    busy_o,
  output logic [15:0]             dropped_o
);

  localparam int WORDS  = 2 * NUM_COUNTERS;
  localparam int WORD_W = $clog2(WORDS);
  localparam logic [WORD_W-1:0]     LAST_WORD = WORD_W'(WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_COUNTERS - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, HEADER, STREAM} state_t;

  state_t                  state_reg;
  logic [PERIOD_WIDTH-1:0] timer_reg;
  logic [PERIOD_WIDTH:0]   timer_inc;
  logic                    timer_fire;
  logic                    trig_eff;
  logic [7:0]              seq_reg;
  logic [WORD_W-1:0]       word_reg;
  logic [WORD_W-1:0]       word_next;
  logic [63:0]             buf_mem [NUM_COUNTERS];

  // One extra bit on the increment so a period near the top of the range
  // cannot wrap the comparison.
  assign timer_inc  = {1'b0, timer_reg} + (PERIOD_WIDTH + 1)'(1);
  assign timer_fire = (period_i != '0) && (timer_inc >= {1'b0, period_i});
  // Software and timer requests in the same cycle collapse into one trigger.
  assign trig_eff   = trigger_i | timer_fire;
  assign busy_o     = (state_reg != IDLE);
  assign word_next  = word_reg + WORD_W'(1);

  // Even words carry the low half of a counter, odd words the high half.
  function automatic logic [31:0] buf_word(input logic [WORD_W-1:0] w);
    logic [63:0] entry;
    entry = buf_mem[w[WORD_W-1:1]];
    return w[0] ? entry[63:32] : entry[31:0];
  endfunction

  // Free-running periodic timer; keeps running while a frame is in flight.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      timer_reg <= '0;
    else if (period_i == '0 || timer_fire)
      timer_reg <= '0;
    else
      timer_reg <= timer_inc[PERIOD_WIDTH-1:0];
  end

  // Saturating count of triggers that arrive while a snapshot is in progress.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      dropped_o <= '0;
    else if (trig_eff && state_reg != IDLE && dropped_o != 16'hFFFF)
      dropped_o <= dropped_o + 16'd1;
  end

  // Snapshot buffer: one counter captured per CAPTURE cycle at the swept address.
  always_ff @(posedge aclk) begin
    if (state_reg == CAPTURE)
      buf_mem[pmu_addr_o] <= pmu_data_i;
  end

  // Sweep / header / stream sequencer with registered stream outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg  <= IDLE;
      pmu_addr_o <= '0;
      word_reg   <= '0;
      seq_reg    <= '0;
      m_tvalid   <= 1'b0;
      m_tlast    <= 1'b0;
      m_tdata    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (trig_eff) begin
            state_reg  <= CAPTURE;
            pmu_addr_o <= '0;
          end
        end
        CAPTURE: begin
          if (pmu_addr_o == LAST_ADDR) begin
            pmu_addr_o <= '0;
            state_reg  <= HEADER;
            m_tvalid   <= 1'b1;
            m_tlast    <= 1'b0;
            m_tdata    <= {SYNC_TAG, 8'(NUM_COUNTERS), seq_reg};
          end else begin
            pmu_addr_o <= pmu_addr_o + ADDR_WIDTH'(1);
          end
        end
        HEADER: begin
          if (m_tready) begin
            seq_reg   <= seq_reg + 8'd1;
            word_reg  <= '0;
            m_tdata   <= buf_word('0);
            m_tlast   <= 1'b0;
            state_reg <= STREAM;
          end
        end
        STREAM: begin
          if (m_tready) begin
            if (m_tlast) begin
              state_reg <= IDLE;
              m_tvalid  <= 1'b0;
              m_tlast   <= 1'b0;
              m_tdata   <= '0;
            end else begin
              word_reg <= word_next;
              m_tdata  <= buf_word(word_next);
              m_tlast  <= (word_next == LAST_WORD);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
